// File: rtl/demux_pkg.sv
// demux_pkg: shared defaults, pointer sizing helper and select encoding for demux1to2_buf.
package demux_pkg;
    localparam int WIDTH_DEF = 32;
    localparam int DEPTH_DEF = 2;
    localparam int CNT_W_DEF = 16;
    typedef enum logic {DST0 = 1'b0, DST1 = 1'b1} dst_e;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: registered-storage FIFO with extra-MSB pointers; storage cleared on reset.
module sync_fifo
    import demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = clog2(DEPTH);
    logic [AW:0]      wr_ptr, rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    assign empty = wr_ptr == rd_ptr;
    assign full  = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
    assign rdata = mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push && !full) begin
                mem[wr_ptr[AW-1:0]] <= wdata;
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end
endmodule

// File: rtl/demux1to2_buf.sv
// demux1to2_buf: buffered 1-to-2 stream demux, one FIFO per destination.
// Define DEMUX_CNT_EN to build the delivered-word counters (CNT_W, dst0_cnt_o, dst1_cnt_o).
module demux1to2_buf
    import demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
`ifdef DEMUX_CNT_EN
    ,
    parameter int CNT_W = CNT_W_DEF
`endif
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             src_valid_i,
    output logic             src_ready_o,
    input  logic [WIDTH-1:0] src_data_i,
    input  logic             sel_i,
    output logic             dst0_valid_o,
    input  logic             dst0_ready_i,
    output logic [WIDTH-1:0] dst0_data_o,
    output logic             dst1_valid_o,
    input  logic             dst1_ready_i,
    output logic [WIDTH-1:0] dst1_data_o
`ifdef DEMUX_CNT_EN
    ,
    output logic [CNT_W-1:0] dst0_cnt_o,
    output logic [CNT_W-1:0] dst1_cnt_o
`endif
);
    dst_e sel;
    logic full0, full1, empty0, empty1, accept, pop0, pop1;
    assign sel          = dst_e'(sel_i);
    assign src_ready_o  = (sel == DST1) ? !full1 : !full0;
    assign accept       = src_valid_i && src_ready_o;
    assign dst0_valid_o = !empty0;
    assign dst1_valid_o = !empty1;
    assign pop0         = dst0_valid_o && dst0_ready_i;
    assign pop1         = dst1_valid_o && dst1_ready_i;
    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
        .clk_i(clk_i), .rst_i(rst_i), .push(accept && sel == DST0), .pop(pop0),
        .wdata(src_data_i), .rdata(dst0_data_o), .full(full0), .empty(empty0)
    );
    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
        .clk_i(clk_i), .rst_i(rst_i), .push(accept && sel == DST1), .pop(pop1),
        .wdata(src_data_i), .rdata(dst1_data_o), .full(full1), .empty(empty1)
    );
`ifdef DEMUX_CNT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dst0_cnt_o <= '0;
            dst1_cnt_o <= '0;
        end else begin
            dst0_cnt_o <= dst0_cnt_o + CNT_W'(pop0);
            dst1_cnt_o <= dst1_cnt_o + CNT_W'(pop1);
        end
    end
`else
`endif
endmodule

// File: doc/demux1to2_buf.md
# demux1to2_buf

Buffered 1-to-2 stream demultiplexer: accepts one 32-bit word per cycle from a single valid/ready source and routes it, by a per-word select bit, into one of two independent output queues. It is the distribution counterpart of the datapath 2-to-1 select: a single producer, such as a fetch/decode stage, feeds two consumers, such as two functional-unit issue ports or a memory/ALU split. Each destination is backed by its own small FIFO, so one stalled consumer does not block words bound for the other once they are queued.

## Interface
Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 2, entries per output FIFO; power of two, at least 2.
- CNT_W, 16, width of the optional transfer counters.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- src_valid_i  in  1  source word present.
- src_ready_o  out  1  block can accept the current source word.
- src_data_i  in  WIDTH  source word.
- sel_i  in  1  destination of the current word: 0 routes to dst0, 1 routes to dst1.
- dst0_valid_o  out  1  dst0 head word valid.
- dst0_ready_i  in  1  dst0 consumer accepts the head word.
- dst0_data_o  out  WIDTH  dst0 head word.
- dst1_valid_o, dst1_ready_i, dst1_data_o: same as dst0, for destination 1.
- dst0_cnt_o  out  CNT_W  words delivered on dst0; present only with DEMUX_CNT_EN.
- dst1_cnt_o  out  CNT_W  words delivered on dst1; present only with DEMUX_CNT_EN.

## Operation
- src_ready_o is combinational. It equals NOT full of the FIFO selected by sel_i and must not depend on src_valid_i.
- Push: when src_valid_i && src_ready_o, src_data_i is written at the selected FIFO's write pointer.
- Pop: when dstN_valid_o && dstN_ready_i, dstN's read pointer advances.
- dstN_valid_o is NOT empty. dstN_data_o is the FIFO head, read from registered storage, so there is no src-to-dst combinational path.
- Each FIFO uses wr_ptr and rd_ptr of log2(DEPTH)+1 bits.
  - Empty when the pointers are equal.
  - Full when the MSBs differ and the remaining bits are equal.
  - Pointers wrap naturally.
- Ordering: words to the same destination leave in arrival order. There is no ordering guarantee between the two destinations.
- Simultaneous push and pop on the same FIFO:
  - Non-empty and non-full: both take effect and occupancy is unchanged.
  - Full: the push is refused because ready is low, even if the consumer pops that cycle. There is no full-bypass.
  - Empty: no pop is possible, so only the push occurs.
- Push to one FIFO and pop from the other in the same cycle are fully independent.
- The source may change sel_i or src_data_i while src_valid_i is high and ready is low. The block samples them only on the accepting edge.
- Reset, including reset asserted mid-stream:
  - All pointers return to 0 and queued words are discarded.
  - dstN_valid_o = 0, dstN_data_o = 0 (storage cleared), counters = 0.
  - src_ready_o = 1 from the first cycle after reset.

## Timing
- Latency: a word accepted at edge k appears on dstN_valid_o/dstN_data_o after edge k, i.e. one cycle, if its FIFO was empty. Otherwise it appears after all earlier words for that destination have been popped.
- Throughput: one push per cycle, plus one pop per destination per cycle.
- src_ready_o reflects full status after the previous edge. Combinationally it follows sel_i only.
- With DEMUX_CNT_EN, dstN_cnt_o increments on each dstN pop edge and wraps from 2^CNT_W-1 to 0.

## Configuration
- DEMUX_CNT_EN defined: two CNT_W-bit delivered-word counters are built and the dst0_cnt_o/dst1_cnt_o ports exist. They are used for pipeline utilisation statistics.
- DEMUX_CNT_EN undefined: the counters and ports are absent. All other behaviour is identical.

## Structure
- Package demux_pkg:
  - Default WIDTH, DEPTH and CNT_W constants.
  - Function clog2 for pointer sizing.
  - Typedef for the select encoding: DST0 = 1'b0, DST1 = 1'b1.
- Sub-module sync_fifo (WIDTH, DEPTH), instantiated twice.
  - Ports: clk_i, rst_i, push, pop, wdata, rdata, full, empty.
  - Top level holds only the select steering and the optional counters.

## Test plan
- Reset, then push 0xA5A5_0001 with sel_i=0 while dst0_ready_i=1 → dst0_valid_o=1 with that data one cycle later, then dst0_valid_o=0 after the pop; dst1_valid_o stays 0.
- Hold dst1_ready_i=0 and push 0x11 and 0x22 to dst1 → after the second push src_ready_o=0 while sel_i=1 and 1 while sel_i=0; a third word with sel_i=0 is accepted and delivered on dst0.
- dst1 full (0x11, 0x22); in one cycle raise dst1_ready_i with src_valid_i=1, sel_i=1, data 0x33 → the pop occurs, the push is refused; 0x33 is accepted the next cycle and the output order is 0x11, 0x22, 0x33.
- Interleaved stream 1,2,3,4,5,6 with sel pattern 0,1,0,1,1,0, both readies tied high → dst0 delivers 1,3,6 and dst1 delivers 2,4,5, each one cycle after acceptance.
- Fill dst0 with two words, assert rst_i for one cycle → the next cycle shows both valids=0, both data=0, src_ready_o=1, and counters 0 when DEMUX_CNT_EN is defined.
- With DEMUX_CNT_EN and CNT_W=4: deliver 17 words on dst0 → dst0_cnt_o=1 after wrap, dst1_cnt_o=0.
